// File: rtl/cond_pkg.sv
// Shared types and constants for the conditional-execution logic.
package cond_pkg;

   localparam int unsigned FLAG_W = 4;
   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_CS = 4'b0010,
      COND_CC = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_VS = 4'b0110,
      COND_VC = 4'b0111,
      COND_HI = 4'b1000,
      COND_LS = 4'b1001,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110,
      COND_NV = 4'b1111
   } cond_e;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of a 4-bit condition field against stored NZCV flags.
module cond_check
   import cond_pkg::*;
(
   input  logic [3:0]        Cond,
   input  logic [FLAG_W-1:0] Flags,
   output logic              CondEx
);

   logic n, z, c, v;

   assign n = Flags[FLAG_N];
   assign z = Flags[FLAG_Z];
   assign c = Flags[FLAG_C];
   assign v = Flags[FLAG_V];

   always_comb begin
      CondEx = 1'b1;
      case (cond_e'(Cond))
         COND_EQ: CondEx = z;
         COND_NE: CondEx = ~z;
         COND_CS: CondEx = c;
         COND_CC: CondEx = ~c;
         COND_MI: CondEx = n;
         COND_PL: CondEx = ~n;
         COND_VS: CondEx = v;
         COND_VC: CondEx = ~v;
         COND_HI: CondEx = c & ~z;
         COND_LS: CondEx = ~c | z;
         COND_GE: CondEx = (n == v);
         COND_LT: CondEx = (n != v);
         COND_GT: CondEx = ~z & (n == v);
         COND_LE: CondEx = z | (n != v);
         // 1111 is executed unconditionally, same as AL
         default: CondEx = 1'b1;
      endcase
   end

endmodule

// File: rtl/cond_unit.sv
// Flags register, condition gating of control strobes, and executed/squashed counters.
module cond_unit
   import cond_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ExStb,
   input  logic [3:0]        Cond,
   input  logic [FLAG_W-1:0] ALUFlags,
   input  logic [1:0]        FlagW,
   input  logic              PCS,
   input  logic              RegW,
   input  logic              MemW,
   input  logic              NoWrite,
   output logic              PCSrc,
   output logic              RegWrite,
   output logic              MemWrite,
   output logic              CondEx,
   output logic [FLAG_W-1:0] Flags,
   output logic              CondExD,
   output logic [CNT_W-1:0]  ExecCnt,
   output logic [CNT_W-1:0]  SquashCnt
);

   logic fire;

   // Evaluated against the registered flags only; ALUFlags never bypasses.
   cond_check u_check (
      .Cond   (Cond),
      .Flags  (Flags),
      .CondEx (CondEx)
   );

   assign fire     = ExStb & CondEx;
   assign PCSrc    = PCS & fire;
   assign MemWrite = MemW & fire;
   assign RegWrite = RegW & ~NoWrite & fire;

   always_ff @(posedge clk) begin
      if (reset) begin
         Flags     <= '0;
         CondExD   <= 1'b0;
         ExecCnt   <= '0;
         SquashCnt <= '0;
      end else if (ExStb) begin
         CondExD <= CondEx;
         if (CondEx) begin
            ExecCnt <= ExecCnt + CNT_W'(1);
            if (FlagW[1]) begin
               Flags[FLAG_N] <= ALUFlags[FLAG_N];
               Flags[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (FlagW[0]) begin
               Flags[FLAG_C] <= ALUFlags[FLAG_C];
               Flags[FLAG_V] <= ALUFlags[FLAG_V];
            end
         end else begin
            SquashCnt <= SquashCnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed cases pinned to literals plus randomized traffic vs a model.
module tb_cond_unit;

   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             ExStb = 1'b0;
   logic [3:0]       Cond = 4'h0;
   logic [3:0]       ALUFlags = 4'h0;
   logic [1:0]       FlagW = 2'b00;
   logic             PCS = 1'b0;
   logic             RegW = 1'b0;
   logic             MemW = 1'b0;
   logic             NoWrite = 1'b0;
   logic             PCSrc, RegWrite, MemWrite, CondEx, CondExD;
   logic [3:0]       Flags;
   logic [CNT_W-1:0] ExecCnt, SquashCnt;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   cond_unit #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .ExStb(ExStb), .Cond(Cond), .ALUFlags(ALUFlags),
      .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
      .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
      .Flags(Flags), .CondExD(CondExD), .ExecCnt(ExecCnt), .SquashCnt(SquashCnt)
   );

   always #5 clk = ~clk;

   // Reference state
   logic [3:0]       m_flags = 4'h0;
   bit               m_cexd = 1'b0;
   logic [CNT_W-1:0] m_exec = '0;
   logic [CNT_W-1:0] m_sq = '0;

   // Conditions come in complementary pairs: odd code = negation of the even code below it.
   function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v, base;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (c[3:1] == 3'd7) return 1'b1;
      return base ^ c[0];
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_flags = 4'h0; m_cexd = 1'b0; m_exec = '0; m_sq = '0;
      end else if (ExStb) begin
         bit ce;
         ce = m_cond(Cond, m_flags);
         m_cexd = ce;
         if (ce) begin
            m_exec = m_exec + 1'b1;
            if (FlagW[1]) m_flags[3:2] = ALUFlags[3:2];
            if (FlagW[0]) m_flags[1:0] = ALUFlags[1:0];
         end else begin
            m_sq = m_sq + 1'b1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every output against the model each cycle
   always @(negedge clk) begin
      if (check_en) begin
         bit ce;
         ce = m_cond(Cond, m_flags);
         chk("CondEx", 32'(CondEx), 32'(ce));
         chk("PCSrc", 32'(PCSrc), 32'(PCS & ce & ExStb));
         chk("MemWrite", 32'(MemWrite), 32'(MemW & ce & ExStb));
         chk("RegWrite", 32'(RegWrite), 32'(RegW & !NoWrite & ce & ExStb));
         chk("Flags", 32'(Flags), 32'(m_flags));
         chk("CondExD", 32'(CondExD), 32'(m_cexd));
         chk("ExecCnt", 32'(ExecCnt), 32'(m_exec));
         chk("SquashCnt", 32'(SquashCnt), 32'(m_sq));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ExStb = 1'b0; Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00;
      PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
   endtask

   task automatic load_flags(input logic [3:0] f);
      idle();
      ExStb = 1'b1; Cond = 4'hE; FlagW = 2'b11; ALUFlags = f;
      cyc();
      idle();
   endtask

   initial begin
      reset = 1'b1;
      idle();
      cyc();
      check_en = 1'b1;
      cyc();
      reset = 1'b0;
      chk("rst_flags", 32'(Flags), 32'h0);
      chk("rst_condexd", 32'(CondExD), 32'h0);
      chk("rst_exec", 32'(ExecCnt), 32'h0);
      chk("rst_squash", 32'(SquashCnt), 32'h0);

      // EQ squashed on cleared flags, NE passes
      ExStb = 1'b1; Cond = 4'h0; #1;
      chk("eq_zero_flags", 32'(CondEx), 32'h0);
      Cond = 4'h1; #1;
      chk("ne_zero_flags", 32'(CondEx), 32'h1);
      Cond = 4'h0;
      cyc();
      chk("squash_cnt_1", 32'(SquashCnt), 32'h1);
      chk("flags_after_squash", 32'(Flags), 32'h0);

      // AL with full flag write
      idle();
      ExStb = 1'b1; Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'h6; RegW = 1'b1; #1;
      chk("al_regwrite", 32'(RegWrite), 32'h1);
      cyc();
      chk("flags_0110", 32'(Flags), 32'h6);
      idle(); #1;
      chk("eq_after_z", 32'(CondEx), 32'h1);

      // Partial flag write: only N,Z
      load_flags(4'hF);
      ExStb = 1'b1; Cond = 4'hE; FlagW = 2'b10; ALUFlags = 4'h0;
      cyc();
      chk("partial_write", 32'(Flags), 32'h3);

      // Squashed instruction: no strobes, no flag write
      load_flags(4'h4);
      ExStb = 1'b1; Cond = 4'h1; PCS = 1'b1; MemW = 1'b1; FlagW = 2'b11; ALUFlags = 4'h8; #1;
      chk("squash_pcsrc", 32'(PCSrc), 32'h0);
      chk("squash_memwrite", 32'(MemWrite), 32'h0);
      cyc();
      chk("squash_flags_hold", 32'(Flags), 32'h4);

      // Signed conditions
      load_flags(4'h8);
      Cond = 4'hA; #1; chk("ge_n1v0", 32'(CondEx), 32'h0);
      Cond = 4'hB; #1; chk("lt_n1v0", 32'(CondEx), 32'h1);
      Cond = 4'hC; #1; chk("gt_n1v0", 32'(CondEx), 32'h0);
      Cond = 4'hD; #1; chk("le_n1v0", 32'(CondEx), 32'h1);
      load_flags(4'h9);
      Cond = 4'hA; #1; chk("ge_n1v1", 32'(CondEx), 32'h1);
      Cond = 4'hC; #1; chk("gt_n1v1", 32'(CondEx), 32'h1);
      ExStb = 1'b1; Cond = 4'hE; RegW = 1'b1; NoWrite = 1'b1; #1;
      chk("nowrite", 32'(RegWrite), 32'h0);
      cyc();
      idle();

      // Counter wrap at 4 bits
      reset = 1'b1; cyc(); reset = 1'b0;
      ExStb = 1'b1; Cond = 4'hE;
      for (int i = 0; i < 15; i++) cyc();
      chk("exec_15", 32'(ExecCnt), 32'hF);
      cyc();
      chk("exec_wrap", 32'(ExecCnt), 32'h0);
      idle();

      // Reset dominates a qualifying strobe
      load_flags(4'hF);
      reset = 1'b1; ExStb = 1'b1; Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'h5;
      cyc();
      chk("rst_dom_flags", 32'(Flags), 32'h0);
      chk("rst_dom_exec", 32'(ExecCnt), 32'h0);
      chk("rst_dom_squash", 32'(SquashCnt), 32'h0);
      reset = 1'b0;
      idle();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         reset    = ($urandom_range(63) == 0);
         ExStb    = ($urandom_range(3) != 0);
         Cond     = 4'($urandom_range(15));
         ALUFlags = 4'($urandom_range(15));
         FlagW    = 2'($urandom_range(3));
         PCS      = 1'($urandom_range(1));
         RegW     = 1'($urandom_range(1));
         MemW     = 1'($urandom_range(1));
         NoWrite  = 1'($urandom_range(1));
         cyc();
      end
      reset = 1'b0;
      idle();
      cyc();
      check_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
